ps2_key_encoder: RTL and testbench

Keystroke transmitter that emulates a PS/2 keyboard toward the host-side scancode receiver and letter decoder. It accepts a 5-bit letter code on a valid/ready handshake and maps it to its PS/2 Set-2 make code. It then serialises a full press/release sequence (make, F0, make) onto ps2_clk/ps2_data as 11-bit device-to-host frames. Used for loopback self-test and keystroke injection in the letter-entry path.

---
 rtl/ps2_key_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder
// ---------------------------------------------------------------------------
// Emulates a PS/2 keyboard toward a host-side scancode receiver. A 5-bit
// letter code is accepted on a valid/ready handshake and translated to its
// PS/2 Set-2 make code. The full keystroke {make, F0, make} is then sent on
// ps2_clk/ps2_data as three 11-bit device-to-host frames (start, d0..d7 LSB
// first, odd parity, stop). Each frame is followed by an idle gap of
// GAP_HALVES half-periods with both lines high.
//
// Parameters
//   CLK_DIV     clk cycles per PS/2 half-period (>= 2)
//   GAP_HALVES  idle half-periods after each frame (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   key_code   letter code, captured on accept
//   key_valid  request from source
//   key_ready  high only while idle
//   ps2_clk    emulated PS/2 clock, idle high
//   ps2_data   emulated PS/2 data, idle high
//   busy       high while a keystroke sequence is being sent
//   err        one-cycle pulse when an unmapped code is accepted
// ---------------------------------------------------------------------------
module ps2_key_encoder #(
  parameter int CLK_DIV    = 4000,
  parameter int GAP_HALVES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_HALVES - 1);
  localparam logic [3:0]       STOP_BIT = 4'd10;
  localparam logic [7:0]       BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;     // clk cycles within the current half-period
  logic             phase;       // 0: ps2_clk high half, 1: ps2_clk low half
  logic [3:0]       bit_idx;     // 0 = start .. 10 = stop
  logic [1:0]       byte_idx;    // 0 = make, 1 = F0, 2 = make
  logic [GAP_W-1:0] gap_cnt;     // half-periods elapsed in the gap
  logic [7:0]       make_code;   // make code of the accepted key

  logic             accept;
  logic             map_hit;
  logic [7:0]       map_make;
  logic             half_done;
  logic [7:0]       cur_byte;
  logic             frame_bit;

  // Letter code to Set-2 make code. Returns {hit, make}; hit=0 for unmapped.
  function automatic logic [8:0] map_code(input logic [4:0] code);
    case (code)
      5'b00000: map_code = {1'b1, 8'h1C}; // a
      5'b00001: map_code = {1'b1, 8'h32}; // b
      5'b00010: map_code = {1'b1, 8'h21}; // c
      5'b00011: map_code = {1'b1, 8'h23}; // d
      5'b00100: map_code = {1'b1, 8'h24}; // e
      5'b00101: map_code = {1'b1, 8'h2B}; // f
      5'b00111: map_code = {1'b1, 8'h34}; // g
      5'b01000: map_code = {1'b1, 8'h33}; // h
      5'b01001: map_code = {1'b1, 8'h43}; // i
      5'b01010: map_code = {1'b1, 8'h3B}; // j
      5'b01011: map_code = {1'b1, 8'h42}; // k
      5'b01111: map_code = {1'b1, 8'h4B}; // l
      5'b10000: map_code = {1'b1, 8'h3A}; // m
      5'b10001: map_code = {1'b1, 8'h31}; // n
      5'b10010: map_code = {1'b1, 8'h44}; // o
      5'b10011: map_code = {1'b1, 8'h4D}; // p
      5'b10100: map_code = {1'b1, 8'h15}; // q
      5'b10101: map_code = {1'b1, 8'h2D}; // r
      5'b10110: map_code = {1'b1, 8'h1B}; // s
      5'b10111: map_code = {1'b1, 8'h2C}; // t
      5'b11000: map_code = {1'b1, 8'h3C}; // u
      5'b11001: map_code = {1'b1, 8'h2A}; // v
      5'b11010: map_code = {1'b1, 8'h1D}; // w
      5'b11011: map_code = {1'b1, 8'h22}; // x
      5'b11100: map_code = {1'b1, 8'h35}; // y
      5'b11101: map_code = {1'b1, 8'h1A}; // z
      5'b11111: map_code = {1'b1, 8'h5A}; // ENTR
      default:  map_code = {1'b0, 8'h00}; // 00110, 01100, 01101, 01110, 11110
    endcase
  endfunction

  assign {map_hit, map_make} = map_code(key_code);
  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = key_valid & key_ready;
  assign half_done = (div_cnt == DIV_LAST);
  assign cur_byte  = (byte_idx == 2'd1) ? BREAK_PREFIX : make_code;

  // Bit presented during the current bit cell.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    frame_bit = 1'b1;
    if (bit_idx == 4'd0) begin
      frame_bit = 1'b0;                          // start
    end else if (bit_idx <= 4'd8) begin
      // bit_idx 1..8 carries d0..d7; the 3-bit wrap maps 8 onto index 7.
      frame_bit = cur_byte[bit_idx[2:0] - 3'd1];
    end else if (bit_idx == 4'd9) begin
      frame_bit = ~^cur_byte;                    // odd parity
    end
  end

  // Lines change only on half-period boundaries, so data is always settled
  // a full half-period before ps2_clk falls and held while it is low.
  assign ps2_clk  = !((state == SEND) && phase);
  assign ps2_data = (state == SEND) ? frame_bit : 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && map_hit) state_next = SEND;
      SEND: if (half_done && phase && (bit_idx == STOP_BIT)) state_next = GAP;
      GAP: begin
        if (half_done && (gap_cnt == GAP_LAST)) begin
          state_next = (byte_idx == 2'd2) ? IDLE : SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
      make_code <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      err   <= accept & ~map_hit;

      case (state)
        IDLE: begin
          div_cnt  <= '0;
          phase    <= 1'b0;
          bit_idx  <= '0;
          byte_idx <= '0;
          gap_cnt  <= '0;
          if (accept && map_hit) make_code <= map_make;
        end

        SEND: begin
          if (half_done) begin
            div_cnt <= '0;
            if (phase) begin
              phase   <= 1'b0;
              bit_idx <= (bit_idx == STOP_BIT) ? 4'd0 : bit_idx + 4'd1;
            end else begin
              phase <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        GAP: begin
          if (half_done) begin
            div_cnt <= '0;
            if (gap_cnt == GAP_LAST) begin
              gap_cnt  <= '0;
              byte_idx <= byte_idx + 2'd1;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder (CLK_DIV=4, GAP_HALVES=2).
// A driver issues keystrokes and pushes the expected frames / error pulses
// into a queue; an independent monitor decodes ps2_clk/ps2_data frames and
// err pulses and compares them against the queue.
module tb_ps2_key_encoder;

  localparam int CLK_DIV    = 4;
  localparam int GAP_HALVES = 2;
  localparam int SEQ_CYCLES = 3 * (22 + GAP_HALVES) * CLK_DIV;

  localparam logic [4:0] REF_CODES [27] = '{
    5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00111,
    5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001,
    5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11000,
    5'b11001, 5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11111};
  localparam logic [7:0] REF_MAKES [27] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h5A};

  typedef struct {
    bit         is_err;
    logic [7:0] byte_val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic       key_ready, ps2_clk, ps2_data, busy, err;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  ps2_key_encoder #(
    .CLK_DIV   (CLK_DIV),
    .GAP_HALVES(GAP_HALVES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lookup: make code for a letter code, -1 when unmapped.
  function automatic int ref_make(input logic [4:0] c);
    for (int i = 0; i < 27; i++) begin
      if (REF_CODES[i] == c) return int'(REF_MAKES[i]);
    end
    return -1;
  endfunction

  // Present a code at a negedge, wait for ready, record expectations, and
  // return at the negedge following the accept edge.
  task automatic issue(input logic [4:0] code, input bit keep, output int waited);
    int   mk;
    exp_t e;
    mk        = ref_make(code);
    waited    = 0;
    key_code  = code;
    key_valid = 1'b1;
    while (!key_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!key_ready) begin
      check("accept_timeout", key_ready, 1);
      key_valid = 1'b0;
      return;
    end
    if (mk < 0) begin
      e.is_err = 1'b1; e.byte_val = 8'h00; exp_q.push_back(e);
    end else begin
      e.is_err = 1'b0;
      e.byte_val = 8'(mk);  exp_q.push_back(e);
      e.byte_val = 8'hF0;   exp_q.push_back(e);
      e.byte_val = 8'(mk);  exp_q.push_back(e);
    end
    @(negedge clk);
    if (!keep) key_valid = 1'b0;
    if (mk < 0) begin
      check("unmapped_err", err, 1);
      check("unmapped_busy", busy, 0);
      check("unmapped_ready", key_ready, 1);
      check("unmapped_lines", {ps2_clk, ps2_data}, 2'b11);
      @(negedge clk);
      check("unmapped_err_1cyc", err, 0);
    end else begin
      check("start_busy", busy, 1);
      check("start_bit", {ps2_clk, ps2_data}, 2'b10);
    end
  endtask

  // Called in the start-bit cycle; waits for busy to fall and checks timing.
  task automatic wait_done(input bit check_fall);
    int cyc = 1;
    int first_fall = -1;
    while (busy && cyc < 2000) begin
      @(negedge clk);
      if (busy) begin
        if (!ps2_clk && first_fall < 0) first_fall = cyc;
        cyc++;
      end
    end
    check("done_timeout", busy, 0);
    check("busy_length", cyc, SEQ_CYCLES);
    if (check_fall) check("first_clk_fall", first_fall, CLK_DIV);
    check("done_ready", key_ready, 1);
  endtask

  // Monitor: decode frames at ps2_clk falling edges, track err pulses.
  initial begin : monitor
    logic        pc;
    logic        pd;
    int          nb;
    logic [10:0] fr;
    logic [7:0]  rx;
    exp_t        e;
    pc = 1'b1; pd = 1'b1; nb = 0; fr = '1;
    forever begin
      @(negedge clk);
      if (reset) begin
        nb = 0;
      end else begin
        if (err) begin
          if (exp_q.size() == 0) begin
            check("err_unexpected", err, 0);
          end else begin
            e = exp_q.pop_front();
            check("err_expected", e.is_err, 1);
          end
        end
        if (pc && !ps2_clk) begin
          fr[nb] = ps2_data;
          nb++;
          if (nb == 11) begin
            nb = 0;
            rx = fr[8:1];
            check("frame_start", fr[0], 0);
            check("frame_stop", fr[10], 1);
            if (exp_q.size() == 0) begin
              check("frame_unexpected", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              check("frame_kind", e.is_err, 0);
              check("frame_byte", rx, e.byte_val);
              check("frame_parity", fr[9], ($countones(e.byte_val) % 2 == 0) ? 1 : 0);
            end
          end
        end else if (!pc && !ps2_clk && (ps2_data !== pd)) begin
          check("data_stable_low", ps2_data, pd);
        end
      end
      pc = ps2_clk;
      pd = ps2_data;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int waited;
    int falls;
    int guard;
    int bad;
    logic pc;
    logic [4:0] rc;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ready", key_ready, 1);
    reset = 1'b0;

    // Idle hold with no requests.
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (!(ps2_clk && ps2_data && key_ready && !busy && !err)) bad++;
    end
    check("idle_hold", bad, 0);

    // 'a', ENTR, unmapped.
    issue(5'b00000, 1'b0, waited); wait_done(1'b1);
    issue(5'b11111, 1'b0, waited); wait_done(1'b1);
    issue(5'b00110, 1'b0, waited);
    repeat (3) @(negedge clk);

    // key_valid held: q then w, w accepted the cycle busy falls.
    issue(5'b10100, 1'b1, waited);
    issue(5'b11010, 1'b0, waited);
    check("held_wait", waited, SEQ_CYCLES);
    wait_done(1'b1);
    repeat (3) @(negedge clk);
    check("held_no_dup", busy, 0);

    // Randomised codes, mapped and unmapped.
    for (int i = 0; i < 14; i++) begin
      rc = 5'($urandom_range(0, 31));
      issue(rc, 1'b0, waited);
      if (ref_make(rc) >= 0) wait_done(1'b0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Reset at the ps2_clk low of bit 5 of the F0 frame.
    issue(5'b00000, 1'b0, waited);
    falls = 0; guard = 0; pc = 1'b1;
    while (falls < 17 && guard < 1000) begin
      @(negedge clk);
      if (pc && !ps2_clk) falls++;
      pc = ps2_clk;
      guard++;
    end
    check("reset_point_clk_low", ps2_clk, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_lines", {ps2_clk, ps2_data}, 2'b11);
    check("midrst_ready", key_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    issue(5'b00010, 1'b0, waited); wait_done(1'b1);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
